vga_timing_gen: RTL



---
 rtl/vga_pkg.sv | 35 +++
 rtl/vga_timing_gen_if.sv | 15 +
 rtl/vga_axis_counter.sv | 47 ++++
 rtl/vga_timing_gen.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// vga_pkg: shared timing defaults, totals helpers and the 12-bit colour type
// used by the VGA timing generator and its axis counters.
package vga_pkg;

  localparam int unsigned H_VISIBLE_DEF = 640;
  localparam int unsigned H_FP_DEF      = 16;
  localparam int unsigned H_SYNC_DEF    = 96;
  localparam int unsigned H_BP_DEF      = 48;
  localparam int unsigned V_VISIBLE_DEF = 480;
  localparam int unsigned V_FP_DEF      = 10;
  localparam int unsigned V_SYNC_DEF    = 2;
  localparam int unsigned V_BP_DEF      = 33;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb12_t;

  function automatic int unsigned h_total(input int unsigned vis, input int unsigned fp,
                                          input int unsigned sync, input int unsigned bp);
    return vis + fp + sync + bp;
  endfunction

  function automatic int unsigned v_total(input int unsigned vis, input int unsigned fp,
                                          input int unsigned sync, input int unsigned bp);
    return vis + fp + sync + bp;
  endfunction

  // Counter width able to hold 0..n-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if: link between the timing generator and a pixel source.
//   pxl_x/pxl_y : pixel coordinate offered to the source (0 during blanking)
//   Red/Green/Blue/Draw : the source's combinational reply for that coordinate
// master = timing generator, slave = pixel source.
interface vga_timing_gen_if;
  logic [31:0] pxl_x;
  logic [31:0] pxl_y;
  logic [3:0]  Red;
  logic [3:0]  Green;
  logic [3:0]  Blue;
  logic        Draw;

  modport master (output pxl_x, pxl_y, input Red, Green, Blue, Draw);
  modport slave  (input pxl_x, pxl_y, output Red, Green, Blue, Draw);
endinterface

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: one raster axis (horizontal or vertical).
//   clk, resetN : clock, asynchronous active-low reset
//   adv         : advance by one position this clock
//   cnt         : current position 0..TOTAL-1
//   wrap        : cnt is at TOTAL-1 (the next advance returns to 0)
//   in_sync     : cnt lies in [SYNC_START, SYNC_START+SYNC_LEN-1]
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int unsigned TOTAL      = 800,
  parameter int unsigned SYNC_START = 656,
  parameter int unsigned SYNC_LEN   = 96,
  parameter int unsigned W          = cnt_width(TOTAL)
) (
  input  logic         clk,
  input  logic         resetN,
  input  logic         adv,
  output logic [W-1:0] cnt,
  output logic         wrap,
  output logic         in_sync
);

  logic [W-1:0] cnt_q, cnt_d;
  logic [31:0]  cnt_ext;

  assign cnt_ext = 32'(cnt_q);
  assign cnt     = cnt_q;
  assign wrap    = (cnt_ext == TOTAL - 1);
  // Compared at 32 bits: SYNC_START+SYNC_LEN may equal TOTAL, which need not fit in W.
  assign in_sync = (cnt_ext >= SYNC_START) && (cnt_ext < SYNC_START + SYNC_LEN);

  always_comb begin
    cnt_d = cnt_q;
    if (adv) begin
      cnt_d = wrap ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster timing plus registered colour/sync output stage.
//   clk, resetN       : board clock, asynchronous active-low reset
//   src (master)      : pxl_x/pxl_y out to the pixel source, Red/Green/Blue/Draw back
//   vga_r/g/b         : registered colour to the DAC
//   vga_hs/vga_vs     : registered syncs, aligned with the colour
//   visible           : current coordinate is inside the active area
//   frame_start       : one-clock pulse in the pixel-enable clock of pixel (0,0)
// Each pixel lasts CLK_DIV clocks; the source reply is captured on the last
// clock of the pixel, so the pins lag pxl_x/pxl_y by exactly one pixel.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_VISIBLE   = H_VISIBLE_DEF,
  parameter int unsigned H_FP        = H_FP_DEF,
  parameter int unsigned H_SYNC      = H_SYNC_DEF,
  parameter int unsigned H_BP        = H_BP_DEF,
  parameter int unsigned V_VISIBLE   = V_VISIBLE_DEF,
  parameter int unsigned V_FP        = V_FP_DEF,
  parameter int unsigned V_SYNC      = V_SYNC_DEF,
  parameter int unsigned V_BP        = V_BP_DEF,
  parameter logic        SYNC_ACTIVE = 1'b0,
  parameter int unsigned CLK_DIV     = 2,
  parameter logic [11:0] BG_COLOR    = 12'h000
) (
  input  logic              clk,
  input  logic              resetN,
  vga_timing_gen_if.master  src,
  output logic [3:0]        vga_r,
  output logic [3:0]        vga_g,
  output logic [3:0]        vga_b,
  output logic              vga_hs,
  output logic              vga_vs,
  output logic              visible,
  output logic              frame_start
);

  localparam int unsigned H_TOTAL = h_total(H_VISIBLE, H_FP, H_SYNC, H_BP);
  localparam int unsigned V_TOTAL = v_total(V_VISIBLE, V_FP, V_SYNC, V_BP);
  localparam int unsigned HW      = cnt_width(H_TOTAL);
  localparam int unsigned VW      = cnt_width(V_TOTAL);
  localparam int unsigned DW      = cnt_width(CLK_DIV);

  // Pixel-clock divider; with CLK_DIV=1 the counter is stuck at 0 and pix_en is always high.
  logic [DW-1:0] div_cnt_q, div_cnt_d;
  logic          pix_en;

  assign pix_en = (32'(div_cnt_q) == CLK_DIV - 1);

  always_comb begin
    div_cnt_d = pix_en ? '0 : div_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      div_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
    end
  end

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic          h_wrap, v_wrap, h_sync, v_sync;

  vga_axis_counter #(
    .TOTAL      (H_TOTAL),
    .SYNC_START (H_VISIBLE + H_FP),
    .SYNC_LEN   (H_SYNC)
  ) u_h_axis (
    .clk     (clk),
    .resetN  (resetN),
    .adv     (pix_en),
    .cnt     (h_cnt),
    .wrap    (h_wrap),
    .in_sync (h_sync)
  );

  vga_axis_counter #(
    .TOTAL      (V_TOTAL),
    .SYNC_START (V_VISIBLE + V_FP),
    .SYNC_LEN   (V_SYNC)
  ) u_v_axis (
    .clk     (clk),
    .resetN  (resetN),
    .adv     (pix_en && h_wrap),
    .cnt     (v_cnt),
    .wrap    (v_wrap),
    .in_sync (v_sync)
  );

  assign visible     = (32'(h_cnt) < H_VISIBLE) && (32'(v_cnt) < V_VISIBLE);
  assign src.pxl_x   = visible ? 32'(h_cnt) : '0;
  assign src.pxl_y   = visible ? 32'(v_cnt) : '0;
  assign frame_start = pix_en && (h_cnt == '0) && (v_cnt == '0);

  // Output stage: colour and both syncs come from the same counter state,
  // so they leave together one pixel later.
  rgb12_t rgb_q, rgb_d;
  logic   hs_q, hs_d, vs_q, vs_d;

  always_comb begin
    rgb_d = rgb_q;
    hs_d  = hs_q;
    vs_d  = vs_q;
    if (pix_en) begin
      if (!visible) begin
        rgb_d = '0;
      end else if (src.Draw) begin
        rgb_d = rgb12_t'({src.Red, src.Green, src.Blue});
      end else begin
        rgb_d = rgb12_t'(BG_COLOR);
      end
      hs_d = h_sync ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      vs_d = v_sync ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      rgb_q <= '0;
      hs_q  <= ~SYNC_ACTIVE;
      vs_q  <= ~SYNC_ACTIVE;
    end else begin
      rgb_q <= rgb_d;
      hs_q  <= hs_d;
      vs_q  <= vs_d;
    end
  end

  assign vga_r  = rgb_q.r;
  assign vga_g  = rgb_q.g;
  assign vga_b  = rgb_q.b;
  assign vga_hs = hs_q;
  assign vga_vs = vs_q;

  // v_wrap is part of the axis interface but frame wrap is implied by the counter itself.
  logic unused_v_wrap;
  assign unused_v_wrap = v_wrap;

endmodule
